cmd_proc: RTL

- Command processor between the UART command wrapper (upstream, supplies 16-bit cmd/cmd_rdy) and the inertial/PID/motor path (downstream, consumes heading, frwrd, moving).
- Decodes calibrate / move / move-with-fanfare / tour commands and sequences calibration handshakes.
- Turns the knight to the commanded heading, ramps forward speed up, counts centre-IR line crossings, then ramps down and acknowledges.

---
 rtl/cmd_proc.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cmd_proc.sv
`default_nettype none
// ============================================================================
// Module   : cmd_proc
// Purpose  : Knight command processor. Decodes UART commands, sequences gyro
//            calibration, and runs turn / ramp-up / ramp-down moves.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_proc #(
    parameter int          FAST_SIM   = 1,
    parameter logic [11:0] ERR_THRESH = 12'h02C,
    parameter logic [9:0]  MAX_FRWRD  = 10'h300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic [11:0] error,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        tour_go,
    output logic        fanfare_go,
    input  logic        cntrIR
);

    localparam logic [9:0] c_INC = (FAST_SIM != 0) ? 10'h020 : 10'h004;
    localparam logic [9:0] c_DEC = {c_INC[8:0], 1'b0};

    localparam logic [3:0] c_OP_CAL  = 4'h2;
    localparam logic [3:0] c_OP_MOVE = 4'h4;
    localparam logic [3:0] c_OP_FAN  = 4'h5;
    localparam logic [3:0] c_OP_TOUR = 4'h6;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_CAL       = 3'd1;
    localparam logic [2:0] c_ST_TURN      = 3'd2;
    localparam logic [2:0] c_ST_RAMP_UP   = 3'd3;
    localparam logic [2:0] c_ST_RAMP_DOWN = 3'd4;
    localparam logic [2:0] c_ST_DONE      = 3'd5;

    logic [2:0]  r_state;
    logic [11:0] r_heading;
    logic [9:0]  r_frwrd;
    logic [3:0]  r_squares;
    logic [4:0]  r_line_cnt;
    logic        r_fanfare_req;
    logic        r_moving;
    logic        r_strt_cal;
    logic        r_send_resp;
    logic        r_tour_go;
    logic        r_fanfare_go;
    logic        r_ir_q;

    logic [11:0] w_err_abs;
    logic        w_settled;
    logic        w_ir_rise;
    logic [10:0] w_up_sum;
    logic [9:0]  w_frwrd_up;
    logic [9:0]  w_frwrd_dn;
    logic [11:0] w_move_heading;
    logic        w_ramping;

    // Magnitude of the signed error; -2048 maps to 12'h800 which is never settled.
    assign w_err_abs  = error[11] ? (~error + 12'd1) : error;
    assign w_settled  = (w_err_abs < ERR_THRESH);
    assign w_ir_rise  = cntrIR & ~r_ir_q;
    assign w_ramping  = (r_state == c_ST_RAMP_UP) || (r_state == c_ST_RAMP_DOWN);

    assign w_up_sum   = {1'b0, r_frwrd} + {1'b0, c_INC};
    assign w_frwrd_up = (w_up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_up_sum[9:0];
    assign w_frwrd_dn = (r_frwrd <= c_DEC) ? 10'h000 : (r_frwrd - c_DEC);

    assign w_move_heading = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};

    // Consumed combinationally so a command that leaves us in IDLE is never re-decoded.
    assign clr_cmd_rdy = (r_state == c_ST_IDLE) && cmd_rdy;

    assign heading    = r_heading;
    assign frwrd      = r_frwrd;
    assign moving     = r_moving;
    assign strt_cal   = r_strt_cal;
    assign send_resp  = r_send_resp;
    assign tour_go    = r_tour_go;
    assign fanfare_go = r_fanfare_go;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_heading     <= 12'h000;
            r_frwrd       <= 10'h000;
            r_squares     <= 4'h0;
            r_line_cnt    <= 5'h00;
            r_fanfare_req <= 1'b0;
            r_moving      <= 1'b0;
            r_strt_cal    <= 1'b0;
            r_send_resp   <= 1'b0;
            r_tour_go     <= 1'b0;
            r_fanfare_go  <= 1'b0;
            r_ir_q        <= 1'b0;
        end else begin
            r_strt_cal   <= 1'b0;
            r_send_resp  <= 1'b0;
            r_tour_go    <= 1'b0;
            r_fanfare_go <= 1'b0;
            r_ir_q       <= cntrIR;

            if (w_ramping && w_ir_rise && (r_line_cnt != 5'h1F))
                r_line_cnt <= r_line_cnt + 5'd1;

            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_rdy) begin
                        case (cmd[15:12])
                            c_OP_CAL: begin
                                r_strt_cal <= 1'b1;
                                r_state    <= c_ST_CAL;
                            end
                            c_OP_MOVE, c_OP_FAN: begin
                                r_heading     <= w_move_heading;
                                r_squares     <= cmd[3:0];
                                r_fanfare_req <= (cmd[15:12] == c_OP_FAN);
                                r_line_cnt    <= 5'h00;
                                r_frwrd       <= 10'h000;
                                r_moving      <= 1'b1;
                                r_state       <= c_ST_TURN;
                            end
                            c_OP_TOUR: r_tour_go <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                c_ST_CAL: begin
                    if (cal_done) begin
                        r_send_resp <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_TURN: begin
                    if (heading_rdy && w_settled) begin
                        if (r_squares != 4'h0) begin
                            r_state <= c_ST_RAMP_UP;
                        end else begin
                            r_moving     <= 1'b0;
                            r_send_resp  <= 1'b1;
                            r_fanfare_go <= r_fanfare_req;
                            r_state      <= c_ST_DONE;
                        end
                    end
                end
                c_ST_RAMP_UP: begin
                    if (r_line_cnt == {r_squares, 1'b0})
                        r_state <= c_ST_RAMP_DOWN;
                    else if (heading_rdy)
                        r_frwrd <= w_frwrd_up;
                end
                c_ST_RAMP_DOWN: begin
                    if (r_frwrd == 10'h000) begin
                        r_moving     <= 1'b0;
                        r_send_resp  <= 1'b1;
                        r_fanfare_go <= r_fanfare_req;
                        r_state      <= c_ST_DONE;
                    end else if (heading_rdy) begin
                        r_frwrd <= w_frwrd_dn;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
